mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store requester that sits between the pipeline's memory stage and the word-indexed data memory (`data_mem`). It drives the memory's `wr_en`/`addr_in`/`data_in` and consumes its `data_out`. It converts byte addresses to word indices and performs sign/zero-extended sub-word loads. Sub-word stores are done as read-modify-write. Pipeline-side transfers use a valid/ready request/response handshake.

## Interface
Parameters:
- `MEM_DEPTH`, 256: number of 32-bit words in the attached memory. Power of two, at least 2.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_op` in 3: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned for SH/SB.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: pipeline accepts response.
- `resp_rdata` out 32: extended load result. 0 for stores and errors.
- `resp_err` out 1: request was misaligned or out of range. No memory access occurred.
- `mem_wr_en` out 1: to memory `wr_en`.
- `mem_addr` out 32: to memory `addr_in`. This is a word index.
- `mem_wdata` out 32: to memory `data_in`.
- `mem_rdata` in 32: from memory `data_out`. Combinational read of `mem_addr`.

## Operation
- States:
  - IDLE
  - RD: memory read cycle.
  - WR: memory write cycle.
  - RESP: holding the response.
- Acceptance: a request is accepted when `req_valid && req_ready`.
  - On acceptance, op, address, and wdata are latched.
  - `req_ready` = (state==IDLE) && !`rst`.
- Word index: `mem_addr` = {2'b00, latched_addr[31:2]}. It holds this value in RD and WR, and is 0 in IDLE and RESP.
- Error checks, evaluated at acceptance:
  - Misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - Out of range: addr[31:2] ≥ `MEM_DEPTH`.
  - An error goes IDLE→RESP with `resp_err`=1 and `resp_rdata`=0. Memory is never written.
- Byte lanes are big-endian:
  - Byte offset 0 = bits [31:24], offset 3 = [7:0].
  - Halfword offset 0 = [31:16], offset 2 = [15:0].
- Load path: IDLE→RD→RESP.
  - In RD, `mem_rdata` is captured and the selected lane is extracted.
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- SW path: IDLE→WR→RESP.
  - In WR: `mem_wdata`=latched wdata, `mem_wr_en`=1.
- SH/SB path: IDLE→RD→WR→RESP.
  - RD captures the old word.
  - WR writes the old word with only the target lane replaced by wdata[15:0] or wdata[7:0].
- RESP:
  - `resp_valid`=1, with `resp_rdata`/`resp_err` held stable.
  - When `resp_ready`=1, return to IDLE. Otherwise stay.
- `mem_wr_en` = (state==WR) && !`rst`. This is asserted exactly one cycle per store and never for loads or errors.
- `mem_wdata` = 0 outside WR.

## Timing
- Reset:
  - State→IDLE.
  - `req_ready`=0 while `rst`=1, then 1 in the first cycle after.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation:
  - The in-flight request is dropped with no response.
  - A WR-state cycle coinciding with `rst`=1 must not write.
- Latency, from the acceptance edge to the first `resp_valid` cycle:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SH/SB: 3 cycles.
- Throughput:
  - One request outstanding at a time.
  - The next request can be accepted in the cycle after the RESP handshake. It is not accepted in the same cycle.
- `resp_ready` held low: RESP persists indefinitely, with outputs unchanged and `req_ready`=0.
- Read-after-write: the memory write lands on the WR edge, so a following load sees the new data.
- Address wrap: none. Addresses at or beyond `MEM_DEPTH` words error and are never truncated.

## Test plan
- After reset: LW at 0x0 with memory word 0 = 0x8899AABB → `resp_rdata`=0x8899AABB and `resp_err`=0, with `resp_valid` 2 cycles after acceptance.
- LB/LBU at 0x5 with word 1 = 0x11F23344 → LB gives 0xFFFFFFF2, LBU gives 0x000000F2. LH at 0x6 gives 0x00003344.
- SB 0xAB at 0x9 over word 2 = 0x01020304 → exactly one `mem_wr_en` pulse with `mem_addr`=2 and `mem_wdata`=0x01AB0304. A subsequent LW at 0x8 returns 0x01AB0304.
- LW at 0x2 and SH at 0x3 → `resp_err`=1 one cycle after acceptance, `mem_wr_en` never asserted.
- SW at byte address 4·`MEM_DEPTH` → `resp_err`=1, no write. SW at 4·(`MEM_DEPTH`−1) → write to the last word.
- Hold `resp_ready`=0 for 5 cycles → response stable and `req_ready`=0 throughout. Assert `rst` during the WR state of an SH → no write, and all outputs reach reset values after the edge.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store requester between the memory stage and a word-indexed data memory.
// Loads take 2 cycles, SW 2, SH/SB 3 (read-modify-write), errors 1; one request in flight.
module mem_access_unit #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;
    localparam logic [30:0] DEPTH_W = 31'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misalign, out_of_range;
    logic [4:0]  byte_sh, half_sh;
    logic [31:0] rd_byte, rd_half, load_val, lane_mask, lane_val, wr_word;

    always_comb begin
        misalign = 1'b0;
        if ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00))
            misalign = 1'b1;
        if ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])
            misalign = 1'b1;
        out_of_range = {1'b0, req_addr[31:2]} >= DEPTH_W;
    end

    // Big-endian lanes: offset 0 is the most significant byte/halfword.
    always_comb begin
        byte_sh  = {~addr_q[1:0], 3'b000};
        half_sh  = addr_q[1] ? 5'd0 : 5'd16;
        rd_byte  = mem_rdata >> byte_sh;
        rd_half  = mem_rdata >> half_sh;
        load_val = mem_rdata;
        case (op_q)
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half[15:0]};
            OP_LHU:  load_val = {16'h0000, rd_half[15:0]};
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte[7:0]};
            OP_LBU:  load_val = {24'h000000, rd_byte[7:0]};
            default: load_val = mem_rdata;
        endcase
        if (op_q == OP_SB) begin
            lane_mask = 32'h0000_00FF << byte_sh;
            lane_val  = {24'h000000, wdata_q[7:0]} << byte_sh;
        end else begin
            lane_mask = 32'h0000_FFFF << half_sh;
            lane_val  = {16'h0000, wdata_q[15:0]} << half_sh;
        end
        wr_word = (op_q == OP_SW) ? wdata_q : ((old_q & ~lane_mask) | lane_val);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = misalign || out_of_range;
                    if (misalign || out_of_range) state_d = S_RESP;
                    else if (req_op == OP_SW)     state_d = S_WR;
                    else                          state_d = S_RD;
                end
            end
            S_RD: begin
                if (op_q == OP_SH || op_q == OP_SB) begin
                    old_d   = mem_rdata;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            default: if (resp_ready) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the handshake and the write strobe combinationally.
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !rst;
        resp_valid = (state_q == S_RESP);
        resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
        resp_err   = (state_q == S_RESP) && err_q;
        mem_wr_en  = (state_q == S_WR) && !rst;
        mem_addr   = (state_q == S_RD || state_q == S_WR) ? {2'b00, addr_q[31:2]} : 32'h0;
        mem_wdata  = (state_q == S_WR) ? wr_word : 32'h0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word memory attached.
module tb_mem_access_unit;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    assign mem_rdata = mem[mem_addr[AW-1:0]];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (mem_wr_en) mem[mem_addr[AW-1:0]] <= mem_wdata;
    end

    // Response monitor: checks the head entry on the first valid cycle, pops on handshake.
    initial begin
        bit front_checked;
        exp_t e;
        front_checked = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                front_checked = 0;
            end else if (resp_valid) begin
                if (!front_checked) begin
                    if (exp_q.size() == 0) begin
                        bad("unexpected_resp");
                    end else begin
                        e = exp_q[0];
                        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                    front_checked = 1;
                end
                if (resp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    front_checked = 0;
                end
            end
        end
    end

    // Write monitor: every write strobe must match the next expected write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (mem_wr_en) begin
                if (wr_q.size() == 0) begin
                    bad("unexpected_write");
                    $display("  write addr %08h data %08h", mem_addr, mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.data);
                end
            end
        end
    end

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_q.push_back('{addr: a, data: d});
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic err, input logic [31:0] rdata, input int lat, input int hold);
        bit ok;
        logic [31:0] held_rdata;
        logic        held_err;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            bad("accept_timeout");
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            return;
        end
        exp_q.push_back('{err: err, rdata: rdata, lat: lat, acc: cyc});
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (hold > 0) begin
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (resp_valid) begin ok = 1; break; end
            end
            if (!ok) bad("hold_resp_timeout");
            held_rdata = resp_rdata;
            held_err   = resp_err;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", {31'b0, resp_valid}, 32'd1);
                chk("hold_rdata", resp_rdata, held_rdata);
                chk("hold_err", {31'b0, resp_err}, {31'b0, held_err});
                chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            end
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin ok = 1; break; end
        end
        if (!ok) bad("resp_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        chk({tag, "_mem_wr_en"}, {31'b0, mem_wr_en}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899AABB;
        mem[1] = 32'h11F23344;
        mem[2] = 32'h01020304;
        mem[4] = 32'h55667788;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk_idle_outputs("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        do_req(LW,  32'h0, 32'h0, 1'b0, 32'h8899AABB, 2, 0);
        do_req(LB,  32'h5, 32'h0, 1'b0, 32'hFFFFFFF2, 2, 0);
        do_req(LBU, 32'h5, 32'h0, 1'b0, 32'h000000F2, 2, 0);
        do_req(LH,  32'h6, 32'h0, 1'b0, 32'h00003344, 2, 0);
        do_req(LH,  32'h0, 32'h0, 1'b0, 32'hFFFF8899, 2, 0);
        do_req(LHU, 32'h4, 32'h0, 1'b0, 32'h000011F2, 2, 0);
        do_req(LB,  32'h3, 32'h0, 1'b0, 32'hFFFFFFBB, 2, 0);

        exp_wr(32'd2, 32'h01AB0304);
        do_req(SB,  32'h9, 32'h000000AB, 1'b0, 32'h0, 3, 0);
        do_req(LW,  32'h8, 32'h0, 1'b0, 32'h01AB0304, 2, 0);

        do_req(LW,  32'h2, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req(SH,  32'h3, 32'hFFFF, 1'b1, 32'h0, 1, 0);
        do_req(SW,  32'(4 * DEPTH), 32'hDEADBEEF, 1'b1, 32'h0, 1, 0);

        exp_wr(32'(DEPTH - 1), 32'hCAFEF00D);
        do_req(SW,  32'(4 * (DEPTH - 1)), 32'hCAFEF00D, 1'b0, 32'h0, 2, 0);
        do_req(LW,  32'(4 * (DEPTH - 1)), 32'h0, 1'b0, 32'hCAFEF00D, 2, 0);

        exp_wr(32'd4, 32'h5566BEEF);
        do_req(SH,  32'h12, 32'h1234BEEF, 1'b0, 32'h0, 3, 0);
        do_req(LHU, 32'h12, 32'h0, 1'b0, 32'h0000BEEF, 2, 0);
        do_req(LH,  32'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 0);

        do_req(LW,  32'h10, 32'h0, 1'b0, 32'h5566BEEF, 2, 5);

        // SH dropped by reset while in its write cycle.
        req_op    = SH;
        req_addr  = 32'h10;
        req_wdata = 32'h0000AAAA;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) bad("rst_sh_accept_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_suppressed", {31'b0, mem_wr_en}, 32'd0);
        chk("rst_wr_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_req(LW,  32'h10, 32'h0, 1'b0, 32'h5566BEEF, 2, 0);

        repeat (3) @(posedge clk);
        chk("pending_resps", 32'(exp_q.size()), 32'd0);
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
